// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath constants and register-file types.
package mips_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NUM_REGS = 1 << AW;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/bit32_zero.sv
// Constant-zero source for the hardwired $zero register read value.
module bit32_zero (
    output logic [31:0] value_o
);

    assign value_o = 32'h0000_0000;

endmodule

// File: rtl/sb_hazard.sv
// Source-operand hazard check against the pending-write scoreboard.
module sb_hazard
    import mips_pkg::*;
#(
    parameter int AW = mips_pkg::AW
) (
    input  logic [(1<<AW)-1:0] pend,
    input  logic [AW-1:0]      rs_addr,
    input  logic [AW-1:0]      rt_addr,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               iss_valid,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    output logic               stall,
    output logic               iss_fire
);

    logic hazard_rs;
    logic hazard_rt;

    // A write-back landing in the same cycle is forwarded, so it resolves the hazard.
    assign hazard_rs = rs_used & pend[rs_addr] & ~(wb_en & (wb_addr == rs_addr));
    assign hazard_rt = rt_used & pend[rt_addr] & ~(wb_en & (wb_addr == rt_addr));

    assign stall    = iss_valid & (hazard_rs | hazard_rt);
    assign iss_fire = iss_valid & ~stall;

endmodule

// File: rtl/reg_file_sb.sv
// MIPS32 register file with write-back bypass and a pending-write scoreboard
// that stalls issue on read-after-write hazards.
module reg_file_sb
    import mips_pkg::*;
#(
    parameter int DW = mips_pkg::DW,
    parameter int AW = mips_pkg::AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       rs_addr,
    input  logic [AW-1:0]       rt_addr,
    input  logic                rs_used,
    input  logic                rt_used,
    output logic [DW-1:0]       rs_data,
    output logic [DW-1:0]       rt_data,
    input  logic                iss_valid,
    input  logic                iss_wr,
    input  logic [AW-1:0]       iss_dst,
    output logic                stall,
    output logic                iss_fire,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [DW-1:0]       wb_data,
    output logic [(1<<AW)-1:0]  pend
);

    localparam int NR = 1 << AW;

    logic [DW-1:0] regs_q [1:NR-1];
    logic [NR-1:0] pend_q;
    logic [NR-1:0] pend_d;
    logic [31:0]   zero_word;
    logic          wb_we;

    bit32_zero u_zero (
        .value_o (zero_word)
    );

    sb_hazard #(.AW(AW)) u_hazard (
        .pend      (pend_q),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .iss_valid (iss_valid),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .stall     (stall),
        .iss_fire  (iss_fire)
    );

    assign wb_we = wb_en & (wb_addr != AW'(REG_ZERO));

    // NOTE: the storage array is reset explicitly because reads after reset must return 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (rs_addr == AW'(REG_ZERO)) begin
            rs_data = zero_word[DW-1:0];
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end
        if (rt_addr == AW'(REG_ZERO)) begin
            rt_data = zero_word[DW-1:0];
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end
    end

    // A new producer supersedes the completing one, so set is applied after clear.
    always_comb begin
        pend_d = pend_q;
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (iss_fire && iss_wr) begin
            pend_d[iss_dst] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule
